// File: rtl/din_syn_sequencer.sv
// Frame sequencer for the DIN/SYN/CLK pattern generator: arbitrates clear/JTAG/key
// requests, sets up the bank, fires the trigger and watches the enables. Optional: DIN_SYN_SEQ_AUTO_RETRIG_EN.
module din_syn_sequencer #(
    parameter int BANK_W       = 2,
    parameter int LOAD_CYCLES  = 2,
    parameter int GAP_CYCLES   = 16,
    parameter int FIRE_TIMEOUT = 64,
    parameter int RUN_TIMEOUT  = 2048,
    parameter int AUTO_PERIOD  = 65536
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              req_jtag,
    input  logic [BANK_W-1:0] bank_jtag,
    input  logic              req_key,
    input  logic [BANK_W-1:0] bank_key,
    input  logic [7:0]        rpt_cnt,
    input  logic              clr_req,
    input  logic              clr_value,
    input  logic              auto_en,
    input  logic              out_en_mon,
    input  logic              clk_out_en_mon,
    output logic              trig,
    output logic [BANK_W-1:0] bank_sel,
    output logic              clr_mode,
    output logic              clr_2_one,
    output logic              ack_jtag,
    output logic              ack_key,
    output logic              ack_clr,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_LOAD, S_FIRE, S_RUN, S_GAP, S_DONE
    } state_t;

    // One shared counter times every state, so it is sized for the longest wait.
    localparam int M1   = (LOAD_CYCLES > GAP_CYCLES) ? LOAD_CYCLES : GAP_CYCLES;
    localparam int M2   = (FIRE_TIMEOUT > RUN_TIMEOUT) ? FIRE_TIMEOUT : RUN_TIMEOUT;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FIRE_LAST = CW'(FIRE_TIMEOUT - 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_TIMEOUT - 1);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        rpt_q;
    logic [BANK_W-1:0] bank_lat_q;
    logic              ptr_q;
    logic              trig_q;
    logic [BANK_W-1:0] bank_sel_q;
    logic              clr_mode_q;
    logic              clr_2_one_q;
    logic              ack_jtag_q;
    logic              ack_key_q;
    logic              ack_clr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic any_en;
    logic auto_pend;
    logic gnt_clr;
    logic gnt_jtag;
    logic gnt_key;
    logic gnt_auto;
    logic gnt_any;

    assign any_en   = out_en_mon | clk_out_en_mon;
    assign gnt_clr  = clr_req;
    assign gnt_jtag = !clr_req && req_jtag && (!req_key || !ptr_q);
    assign gnt_key  = !clr_req && req_key && (!req_jtag || ptr_q);
    assign gnt_auto = !clr_req && !req_jtag && !req_key && auto_pend;
    assign gnt_any  = gnt_clr | gnt_jtag | gnt_key | gnt_auto;

`ifdef DIN_SYN_SEQ_AUTO_RETRIG_EN
    localparam int AW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

    logic [AW-1:0] auto_cnt_q;
    logic          auto_pend_q;
    logic          auto_hit;
    logic          auto_take;

    assign auto_hit  = auto_en && (auto_cnt_q == AUTO_LAST);
    assign auto_take = (state_q == S_IDLE) && gnt_auto;
    assign auto_pend = auto_pend_q;

    // A single pending flag means an expiry during a frame is remembered once, never queued twice.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt_q  <= '0;
            auto_pend_q <= 1'b0;
        end else begin
            if (!auto_en || auto_hit)
                auto_cnt_q <= '0;
            else
                auto_cnt_q <= auto_cnt_q + 1'b1;
            if (auto_hit)
                auto_pend_q <= 1'b1;
            else if (auto_take)
                auto_pend_q <= 1'b0;
        end
    end
`else
    localparam int unused_auto_period = AUTO_PERIOD;
    logic unused_auto_en;
    assign unused_auto_en = auto_en;
    assign auto_pend      = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rpt_q       <= '0;
            bank_lat_q  <= '0;
            ptr_q       <= 1'b0;
            trig_q      <= 1'b0;
            bank_sel_q  <= '0;
            clr_mode_q  <= 1'b0;
            clr_2_one_q <= 1'b0;
            ack_jtag_q  <= 1'b0;
            ack_key_q   <= 1'b0;
            ack_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_jtag_q <= 1'b0;
            ack_key_q  <= 1'b0;
            ack_clr_q  <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                // The grant is decided on the IDLE exit edge so the ack is high throughout ARB.
                S_IDLE: begin
                    if (gnt_any) begin
                        state_q     <= S_ARB;
                        busy_q      <= 1'b1;
                        ack_clr_q   <= gnt_clr;
                        ack_jtag_q  <= gnt_jtag;
                        ack_key_q   <= gnt_key;
                        clr_mode_q  <= gnt_clr;
                        clr_2_one_q <= gnt_clr & clr_value;
                        rpt_q       <= gnt_auto ? 8'd0 : rpt_cnt;
                        if (gnt_jtag) begin
                            bank_lat_q <= bank_jtag;
                            ptr_q      <= 1'b1;
                        end
                        if (gnt_key) begin
                            bank_lat_q <= bank_key;
                            ptr_q      <= 1'b0;
                        end
                        if (gnt_auto)
                            bank_lat_q <= '0;
                    end
                end
                S_ARB: begin
                    state_q    <= S_LOAD;
                    bank_sel_q <= bank_lat_q;
                    cnt_q      <= '0;
                end
                S_LOAD: begin
                    if (cnt_q == LOAD_LAST) begin
                        state_q <= S_FIRE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Completion needs out_en_mon seen while our own trig is high, so a stale enable is not mistaken for a start.
                S_FIRE: begin
                    if (trig_q && out_en_mon) begin
                        trig_q  <= 1'b0;
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end else if (cnt_q == FIRE_LAST) begin
                        trig_q     <= 1'b0;
                        err_q      <= 1'b1;
                        done_q     <= 1'b1;
                        clr_mode_q <= 1'b0;
                        state_q    <= S_DONE;
                    end else begin
                        trig_q <= ~any_en;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!any_en) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                    end else if (cnt_q == RUN_LAST) begin
                        err_q      <= 1'b1;
                        done_q     <= 1'b1;
                        clr_mode_q <= 1'b0;
                        state_q    <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q != GAP_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (rpt_q != 8'd0) begin
                        rpt_q   <= rpt_q - 8'd1;
                        state_q <= S_FIRE;
                        cnt_q   <= '0;
                    end else begin
                        done_q     <= 1'b1;
                        clr_mode_q <= 1'b0;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    trig_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign trig        = trig_q;
    assign bank_sel    = bank_sel_q;
    assign clr_mode    = clr_mode_q;
    assign clr_2_one   = clr_2_one_q;
    assign ack_jtag    = ack_jtag_q;
    assign ack_key     = ack_key_q;
    assign ack_clr     = ack_clr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_din_syn_sequencer.sv
// Directed bench for din_syn_sequencer with a behavioural generator model
// that answers trig by holding both enables high for genLen cycles.
module tb_din_syn_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       req_jtag;
    logic [1:0] bank_jtag;
    logic       req_key;
    logic [1:0] bank_key;
    logic [7:0] rpt_cnt;
    logic       clr_req;
    logic       clr_value;
    logic       auto_en;
    logic       out_en_mon;
    logic       clk_out_en_mon;
    logic       trig;
    logic [1:0] bank_sel;
    logic       clr_mode;
    logic       clr_2_one;
    logic       ack_jtag;
    logic       ack_key;
    logic       ack_clr;
    logic       busy;
    logic       done;
    logic       err_timeout;

    int nChecks = 0;
    int nFails  = 0;

    bit genRespond = 1'b1;
    int genLen     = 20;
    bit forceOe    = 1'b0;
    bit forceCe    = 1'b0;
    bit mActive;
    int mRem;

    int nTrig;
    int nTrigHi;
    int nDone;
    int nViol;
    int lowRun;
    int minGap;
    bit trigPrev;
    bit prevEn;
    int bankLog[$];
    int grantLog[$];

`ifdef DIN_SYN_SEQ_AUTO_RETRIG_EN
    din_syn_sequencer #(.AUTO_PERIOD(100)) dut (
`else
    din_syn_sequencer dut (
`endif
        .clk_in(clk_in), .rst_n(rst_n),
        .req_jtag(req_jtag), .bank_jtag(bank_jtag),
        .req_key(req_key), .bank_key(bank_key),
        .rpt_cnt(rpt_cnt), .clr_req(clr_req), .clr_value(clr_value),
        .auto_en(auto_en), .out_en_mon(out_en_mon), .clk_out_en_mon(clk_out_en_mon),
        .trig(trig), .bank_sel(bank_sel), .clr_mode(clr_mode), .clr_2_one(clr_2_one),
        .ack_jtag(ack_jtag), .ack_key(ack_key), .ack_clr(ack_clr),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk_in = ~clk_in;

    // Generator model: reacts to a high trig just after the edge and drops both enables genLen cycles later.
    initial begin
        mActive = 1'b0;
        mRem = 0;
        out_en_mon = 1'b0;
        clk_out_en_mon = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            if (!rst_n) begin
                mActive = 1'b0;
            end else if (mActive) begin
                mRem = mRem - 1;
                if (mRem <= 0) mActive = 1'b0;
            end else if (trig && genRespond) begin
                mActive = 1'b1;
                mRem = genLen;
            end
            out_en_mon = mActive | forceOe;
            clk_out_en_mon = mActive | forceCe;
        end
    end

    // Passive monitor sampling on the falling edge: trigger rises, pulses, grant order and idle gaps.
    initial begin
        trigPrev = 1'b0;
        prevEn = 1'b0;
        lowRun = 0;
        forever begin
            @(negedge clk_in);
            if (trig && !trigPrev) begin
                nTrig = nTrig + 1;
                if (prevEn) nViol = nViol + 1;
                bankLog.push_back(int'(bank_sel));
                if (nTrig > 1 && lowRun < minGap) minGap = lowRun;
            end
            if (trig) nTrigHi = nTrigHi + 1;
            if (ack_jtag) grantLog.push_back(1);
            if (ack_key) grantLog.push_back(2);
            if (ack_clr) grantLog.push_back(3);
            if (done) nDone = nDone + 1;
            prevEn = out_en_mon | clk_out_en_mon;
            lowRun = prevEn ? 0 : lowRun + 1;
            trigPrev = trig;
        end
    end

    task automatic clear_monitor();
        nTrig = 0;
        nTrigHi = 0;
        nDone = 0;
        nViol = 0;
        minGap = 9999;
        bankLog.delete();
        grantLog.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_jtag = 1'b0; bank_jtag = 2'd0;
        req_key = 1'b0; bank_key = 2'd0;
        rpt_cnt = 8'd0; clr_req = 1'b0; clr_value = 1'b0; auto_en = 1'b0;
        genRespond = 1'b1; genLen = 20; forceOe = 1'b0; forceCe = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        clear_monitor();
    endtask

    // which: 0 done, 1 ack_jtag, 2 ack_key, 3 ack_clr, 4 trig; returns at the falling edge it was seen on.
    task automatic wait_event(input int which, input int maxCycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk_in);
            if ((which == 0 && done) || (which == 1 && ack_jtag) || (which == 2 && ack_key) ||
                (which == 3 && ack_clr) || (which == 4 && trig)) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_jtag = 1'b1; req_key = 1'b1; clr_req = 1'b1;
        repeat (2) @(negedge clk_in);
        nChecks++; if (trig !== 1'b0) begin nFails++; $display("[TB] FAIL reset_trig got %b want 0", trig); end
        nChecks++; if (bank_sel !== 2'd0) begin nFails++; $display("[TB] FAIL reset_bank_sel got %0d want 0", bank_sel); end
        nChecks++; if (clr_mode !== 1'b0) begin nFails++; $display("[TB] FAIL reset_clr_mode got %b want 0", clr_mode); end
        nChecks++; if (clr_2_one !== 1'b0) begin nFails++; $display("[TB] FAIL reset_clr_2_one got %b want 0", clr_2_one); end
        nChecks++; if (ack_jtag !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ack_jtag got %b want 0", ack_jtag); end
        nChecks++; if (ack_key !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ack_key got %b want 0", ack_key); end
        nChecks++; if (ack_clr !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ack_clr got %b want 0", ack_clr); end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got %b want 0", done); end
        nChecks++; if (err_timeout !== 1'b0) begin nFails++; $display("[TB] FAIL reset_err got %b want 0", err_timeout); end
        do_reset();
    endtask

    task automatic test_single_frame();
        bit ok;
        do_reset();
        genLen = 627;
        bank_jtag = 2'd2; rpt_cnt = 8'd0; req_jtag = 1'b1;
        wait_event(1, 20, ok);
        req_jtag = 1'b0;
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL single_ack got none want ack_jtag"); end
        wait_event(0, 1000, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL single_done got none want done pulse"); end
        @(negedge clk_in);
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL single_busy_after got %b want 0", busy); end
        repeat (20) @(negedge clk_in);
        nChecks++; if (nTrig != 1) begin nFails++; $display("[TB] FAIL single_trig_count got %0d want 1", nTrig); end
        nChecks++; if (nDone != 1) begin nFails++; $display("[TB] FAIL single_done_count got %0d want 1", nDone); end
        nChecks++; if (grantLog.size() != 1) begin nFails++; $display("[TB] FAIL single_grants got %0d want 1", grantLog.size()); end
        nChecks++; if (bankLog.size() < 1 || bankLog[0] != 2) begin nFails++; $display("[TB] FAIL single_bank got %0d want 2", (bankLog.size() > 0) ? bankLog[0] : -1); end
        nChecks++; if (err_timeout !== 1'b0) begin nFails++; $display("[TB] FAIL single_err got %b want 0", err_timeout); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int wantGrant[4];
        int wantBank[4];
        wantGrant = '{1, 2, 1, 2};
        wantBank = '{1, 3, 1, 3};
        do_reset();
        bank_jtag = 2'd1; bank_key = 2'd3; rpt_cnt = 8'd0;
        req_jtag = 1'b1; req_key = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_event(0, 300, ok);
            if (!ok) break;
        end
        req_jtag = 1'b0; req_key = 1'b0;
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL b2b_done got timeout want 4 frames"); end
        repeat (10) @(negedge clk_in);
        nChecks++; if (grantLog.size() != 4) begin nFails++; $display("[TB] FAIL b2b_grant_count got %0d want 4", grantLog.size()); end
        for (int k = 0; k < 4; k++) begin
            nChecks++;
            if (grantLog.size() <= k || grantLog[k] != wantGrant[k]) begin
                nFails++; $display("[TB] FAIL b2b_grant%0d got %0d want %0d", k, (grantLog.size() > k) ? grantLog[k] : -1, wantGrant[k]);
            end
            nChecks++;
            if (bankLog.size() <= k || bankLog[k] != wantBank[k]) begin
                nFails++; $display("[TB] FAIL b2b_bank%0d got %0d want %0d", k, (bankLog.size() > k) ? bankLog[k] : -1, wantBank[k]);
            end
        end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_clear_priority();
        bit ok;
        do_reset();
        bank_key = 2'd1; rpt_cnt = 8'd0; clr_value = 1'b1;
        req_key = 1'b1; clr_req = 1'b1;
        wait_event(3, 20, ok);
        clr_req = 1'b0;
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL clr_ack got none want ack_clr"); end
        nChecks++; if (ack_key !== 1'b0) begin nFails++; $display("[TB] FAIL clr_key_blocked got %b want 0", ack_key); end
        nChecks++; if (clr_mode !== 1'b1) begin nFails++; $display("[TB] FAIL clr_mode_set got %b want 1", clr_mode); end
        nChecks++; if (clr_2_one !== 1'b1) begin nFails++; $display("[TB] FAIL clr_2_one_set got %b want 1", clr_2_one); end
        wait_event(2, 300, ok);
        req_key = 1'b0;
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL clr_key_later got none want ack_key"); end
        nChecks++; if (clr_mode !== 1'b0) begin nFails++; $display("[TB] FAIL clr_mode_data got %b want 0", clr_mode); end
        wait_event(0, 300, ok);
        repeat (5) @(negedge clk_in);
        nChecks++; if (nDone != 2) begin nFails++; $display("[TB] FAIL clr_done_count got %0d want 2", nDone); end
        nChecks++; if (grantLog.size() != 2 || grantLog[0] != 3) begin nFails++; $display("[TB] FAIL clr_first got %0d want 3", (grantLog.size() > 0) ? grantLog[0] : -1); end
    endtask

    task automatic test_repeat();
        bit ok;
        do_reset();
        genLen = 30;
        bank_jtag = 2'd3; rpt_cnt = 8'd3; req_jtag = 1'b1;
        wait_event(1, 20, ok);
        req_jtag = 1'b0;
        wait_event(0, 1000, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL rpt_done got none want done pulse"); end
        repeat (40) @(negedge clk_in);
        nChecks++; if (nTrig != 4) begin nFails++; $display("[TB] FAIL rpt_trig_count got %0d want 4", nTrig); end
        nChecks++; if (nDone != 1) begin nFails++; $display("[TB] FAIL rpt_done_count got %0d want 1", nDone); end
        nChecks++; if (minGap < 16) begin nFails++; $display("[TB] FAIL rpt_gap got %0d want >=16", minGap); end
        nChecks++; if (nViol != 0) begin nFails++; $display("[TB] FAIL rpt_trig_while_en got %0d want 0", nViol); end
        nChecks++; if (bankLog.size() != 4 || bankLog[3] != 3) begin nFails++; $display("[TB] FAIL rpt_bank got %0d want 3", (bankLog.size() > 3) ? bankLog[3] : -1); end
    endtask

    task automatic test_fire_timeout();
        bit ok;
        do_reset();
        genRespond = 1'b0;
        bank_key = 2'd2; rpt_cnt = 8'd0; req_key = 1'b1;
        wait_event(2, 20, ok);
        req_key = 1'b0;
        wait_event(0, 200, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL tmo_done got none want done pulse"); end
        nChecks++; if (err_timeout !== 1'b1) begin nFails++; $display("[TB] FAIL tmo_err got %b want 1", err_timeout); end
        nChecks++; if (trig !== 1'b0) begin nFails++; $display("[TB] FAIL tmo_trig got %b want 0", trig); end
        repeat (20) @(negedge clk_in);
        nChecks++; if (err_timeout !== 1'b1) begin nFails++; $display("[TB] FAIL tmo_err_sticky got %b want 1", err_timeout); end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL tmo_busy got %b want 0", busy); end
        nChecks++; if (nTrigHi < 32 || nTrigHi > 64) begin nFails++; $display("[TB] FAIL tmo_trig_high got %0d want 32..64", nTrigHi); end
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++; if (err_timeout !== 1'b0) begin nFails++; $display("[TB] FAIL tmo_err_cleared got %b want 0", err_timeout); end
        do_reset();
    endtask

    task automatic test_stale_enable();
        bit ok;
        do_reset();
        genRespond = 1'b0;
        forceCe = 1'b1;
        bank_jtag = 2'd1; rpt_cnt = 8'd0; req_jtag = 1'b1;
        wait_event(1, 20, ok);
        req_jtag = 1'b0;
        repeat (20) @(negedge clk_in);
        nChecks++; if (nTrig != 0) begin nFails++; $display("[TB] FAIL stale_no_trig got %0d want 0", nTrig); end
        nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL stale_busy got %b want 1", busy); end
        forceCe = 1'b0;
        wait_event(0, 100, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL stale_done got none want done pulse"); end
        nChecks++; if (err_timeout !== 1'b1) begin nFails++; $display("[TB] FAIL stale_err got %b want 1", err_timeout); end
        nChecks++; if (nViol != 0) begin nFails++; $display("[TB] FAIL stale_trig_while_en got %0d want 0", nViol); end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        genLen = 100;
        bank_jtag = 2'd2; rpt_cnt = 8'd0; req_jtag = 1'b1;
        wait_event(1, 20, ok);
        req_jtag = 1'b0;
        wait_event(4, 20, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL areset_trig got none want trig"); end
        #1;
        rst_n = 1'b0;
        #1;
        nChecks++; if (trig !== 1'b0) begin nFails++; $display("[TB] FAIL areset_trig_low got %b want 0", trig); end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL areset_busy got %b want 0", busy); end
        do_reset();
    endtask

    task automatic test_auto_retrig();
        do_reset();
        auto_en = 1'b1;
        repeat (300) @(negedge clk_in);
        auto_en = 1'b0;
        repeat (80) @(negedge clk_in);
`ifdef DIN_SYN_SEQ_AUTO_RETRIG_EN
        nChecks++; if (nTrig < 2) begin nFails++; $display("[TB] FAIL auto_frames got %0d want >=2", nTrig); end
        nChecks++; if (bankLog.size() < 1 || bankLog[0] != 0) begin nFails++; $display("[TB] FAIL auto_bank got %0d want 0", (bankLog.size() > 0) ? bankLog[0] : -1); end
`else
        nChecks++; if (nTrig != 0) begin nFails++; $display("[TB] FAIL auto_disabled got %0d trig want 0", nTrig); end
`endif
        nChecks++; if (grantLog.size() != 0) begin nFails++; $display("[TB] FAIL auto_no_ack got %0d acks want 0", grantLog.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_jtag = 1'b0; bank_jtag = 2'd0;
        req_key = 1'b0; bank_key = 2'd0;
        rpt_cnt = 8'd0; clr_req = 1'b0; clr_value = 1'b0; auto_en = 1'b0;
        clear_monitor();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_clear_priority();
        test_repeat();
        test_fire_timeout();
        test_stale_enable();
        test_async_reset();
        test_auto_retrig();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/din_syn_sequencer.md
Name: din_syn_sequencer

Overview:
- Controller for the serial DIN/SYN/CLK pattern generator.
- Arbitrates frame requests from two requesters (JTAG host, push-button key) and from the clear command. Selects the data-register bank, fires the generator trigger, and monitors the generator's output enables until the frame completes.
- Supports a per-request repeat count with a guaranteed inter-frame gap, plus a timeout on a stuck generator.
- Sits between the vJTAG command decode / key debouncer and the generator, in the same clock domain.

Parameters:
- BANK_W, 2, width of bank select (4 pattern banks).
- LOAD_CYCLES, 2, settle cycles after a bank_sel change before trig.
- GAP_CYCLES, 16, idle cycles between consecutive frames (min 1).
- FIRE_TIMEOUT, 64, max cycles trig may be held waiting for out_en_mon=1.
- RUN_TIMEOUT, 2048, max cycles in RUN waiting for both enables low.
- AUTO_PERIOD, 65536, auto-retrigger period in cycles (optional feature only).

Ports:
- clk_in  in  1  generator bit clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_jtag  in  1  level request, held until ack_jtag.
- bank_jtag  in  BANK_W  bank for JTAG request, sampled at grant.
- req_key  in  1  level request, held until ack_key.
- bank_key  in  BANK_W  bank for key request, sampled at grant.
- rpt_cnt  in  8  extra repeats per granted request (0 = one frame), sampled at grant.
- clr_req  in  1  clear-frame request; highest priority.
- clr_value  in  1  0 = all-zeros clear, 1 = all-ones clear; sampled at grant.
- auto_en  in  1  auto-retrigger enable (ignored unless feature compiled).
- out_en_mon  in  1  generator data output enable.
- clk_out_en_mon  in  1  generator clock output enable.
- trig  out  1  generator trigger.
- bank_sel  out  BANK_W  bank feeding the generator data register.
- clr_mode  out  1  generator clear mode.
- clr_2_one  out  1  generator clear polarity.
- ack_jtag  out  1  one-cycle grant pulse.
- ack_key  out  1  one-cycle grant pulse.
- ack_clr  out  1  one-cycle grant pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a request's last frame completes.
- err_timeout  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; round-robin pointer = JTAG.
- States:
  - IDLE -> ARB when any request is high.
  - ARB, one cycle:
    - Priority: clr_req first, then round-robin between jtag and key. The pointer flips to the non-granted requester after each jtag/key grant.
    - Pulse the matching ack; latch bank, rpt_cnt and clr_value.
    - Clear grant: clr_mode=1, clr_2_one=clr_value. Data grant: clr_mode=0.
    - -> LOAD.
  - LOAD:
    - bank_sel is driven from the latched value.
    - Wait LOAD_CYCLES, then -> FIRE.
  - FIRE:
    - trig=1 until out_en_mon=1 is sampled, then trig=0 and -> RUN. The trig high time is therefore at least 1 cycle.
    - If out_en_mon stays 0 for FIRE_TIMEOUT cycles: set err_timeout, trig=0, -> DONE.
  - RUN:
    - Wait until out_en_mon=0 and clk_out_en_mon=0 in the same sample, then -> GAP.
    - RUN_TIMEOUT expiry: set err_timeout, -> DONE.
  - GAP:
    - Count GAP_CYCLES.
    - Then, if repeats remaining > 0: decrement, -> FIRE (no re-arbitration, bank unchanged).
    - Otherwise -> DONE.
  - DONE, one cycle: pulse done, clr_mode=0, -> IDLE.
- trig never asserts while out_en_mon or clk_out_en_mon is 1. If either enable is high on entry to FIRE, stay in FIRE with trig=0; this wait counts toward FIRE_TIMEOUT.
- bank_sel, clr_mode and clr_2_one stay stable from LOAD through GAP of every frame of a request.
- Requests arriving while busy are not dropped: they stay pending (inputs are levels) and are arbitrated on the next IDLE->ARB.
- Simultaneous jtag+key in ARB: the pointer decides. Simultaneous clr+any: clr wins, and the others stay pending.
- rpt_cnt=255 gives 256 frames; the repeat counter does not wrap.
- A request dropped before its ack is simply not granted. Input changes after the ack are ignored.
- Reset asserted mid-frame: trig=0 immediately (asynchronous), back to IDLE, err_timeout cleared.

Optional Feature:
- Macro: DIN_SYN_SEQ_AUTO_RETRIG_EN.
- Defined:
  - An internal period counter runs while auto_en=1 and is cleared when auto_en=0.
  - On reaching AUTO_PERIOD-1 it raises an internal lowest-priority request using bank 0, rpt 0, with no ack output.
  - A period expiry while busy is held pending, not queued twice.
- Undefined: no counter logic; auto_en is ignored.

Test Plan:
- Reset, then req_jtag=1 with bank_jtag=2, rpt_cnt=0; model the generator raising out_en_mon 1 cycle after trig and dropping it after 627 cycles -> one ack_jtag, bank_sel=2, trig pulse, exactly one done, busy low after DONE.
- req_jtag and req_key high together, held for 4 grants -> grants alternate jtag, key, jtag, key, with the GAP then ARB sequence between them.
- clr_req=1 with clr_value=1 while req_key is high -> ack_clr first with clr_mode=1, clr_2_one=1; key granted on the next arbitration with clr_mode=0.
- rpt_cnt=3 -> 4 trig pulses, each pair separated by ≥GAP_CYCLES=16 idle cycles after the enables drop; done pulses once.
- Generator model never raises out_en_mon -> after 64 cycles trig=0, err_timeout=1, done pulse; err_timeout held until rst_n=0.
- With DIN_SYN_SEQ_AUTO_RETRIG_EN defined, AUTO_PERIOD=100, auto_en=1 and no other requests -> frames start every ≥100 cycles on bank 0. With the macro undefined -> no trig ever.
